// File: rtl/mem_in_arb.sv
// Round-robin, burst-locked arbiter that shares one memory-input request port among NREQ requesters.
// The owner keeps the port for len+1 handshakes; one IDLE bubble always separates bursts.
module mem_in_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned AW   = 32,
  parameter int unsigned DW   = 32,
  parameter int unsigned LW   = 4,
  parameter int unsigned IDW  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*AW-1:0]   req_addr,
  input  logic [NREQ*DW-1:0]   req_wdata,
  input  logic [NREQ-1:0]      req_we,
  input  logic [NREQ*LW-1:0]   req_len,
  output logic                 mem_valid,
  input  logic                 mem_ready,
  output logic [AW-1:0]        mem_addr,
  output logic [DW-1:0]        mem_wdata,
  output logic                 mem_we,
  output logic [IDW-1:0]       gnt_id,
  output logic                 busy
);

  typedef enum logic {IDLE, BURST} state_t;

  state_t         state_q;
  logic [IDW-1:0] rr_ptr_q;
  logic [IDW-1:0] gnt_id_q;
  logic [LW-1:0]  beat_cnt_q;
  logic [LW-1:0]  len_q;
  logic           busy_q;

  logic [AW-1:0]  addr_a [NREQ];
  logic [DW-1:0]  wdata_a[NREQ];
  logic [LW-1:0]  len_a  [NREQ];

  for (genvar g = 0; g < int'(NREQ); g++) begin : g_slice
    assign addr_a[g]  = req_addr[g*AW +: AW];
    assign wdata_a[g] = req_wdata[g*DW +: DW];
    assign len_a[g]   = req_len[g*LW +: LW];
  end

  logic           win_found;
  logic [IDW-1:0] win_idx;
  logic [IDW-1:0] cand_id;
  int unsigned    cand;

  // Search upward from rr_ptr with wrap at NREQ-1, which also covers non-power-of-two NREQ.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    cand_id   = '0;
    cand      = 0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = 32'(rr_ptr_q) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      cand_id = IDW'(cand);
      if (!win_found && req_valid[cand_id]) begin
        win_found = 1'b1;
        win_idx   = cand_id;
      end
    end
  end

  logic in_burst;
  logic hs;
  logic [IDW-1:0] rr_next;

  assign in_burst = (state_q == BURST);
  assign hs       = in_burst & req_valid[gnt_id_q] & mem_ready;
  assign rr_next  = (gnt_id_q == IDW'(NREQ - 1)) ? '0 : gnt_id_q + 1'b1;

  always_comb begin
    req_ready = '0;
    mem_valid = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (in_burst) begin
      req_ready[gnt_id_q] = mem_ready;
      mem_valid           = req_valid[gnt_id_q];
      mem_addr            = addr_a[gnt_id_q];
      mem_wdata           = wdata_a[gnt_id_q];
      mem_we              = req_we[gnt_id_q];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gnt_id_q   <= '0;
      beat_cnt_q <= '0;
      len_q      <= '0;
      busy_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (win_found) begin
            gnt_id_q   <= win_idx;
            len_q      <= len_a[win_idx];
            beat_cnt_q <= '0;
            state_q    <= BURST;
            busy_q     <= 1'b1;
          end
        end
        BURST: begin
          if (hs) begin
            beat_cnt_q <= beat_cnt_q + 1'b1;
            if (beat_cnt_q == len_q) begin
              state_q  <= IDLE;
              busy_q   <= 1'b0;
              rr_ptr_q <= rr_next;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_mem_in_arb.sv
// Directed, table-driven bench for mem_in_arb: one record per clock cycle,
// plus a hand-written burst that changes req_len mid-burst.
module tb_mem_in_arb;

  localparam int NREQ = 4;
  localparam int AW   = 32;
  localparam int DW   = 32;
  localparam int LW   = 4;
  localparam int IDW  = 2;

  logic                 clk;
  logic                 rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*AW-1:0]   req_addr;
  logic [NREQ*DW-1:0]   req_wdata;
  logic [NREQ-1:0]      req_we;
  logic [NREQ*LW-1:0]   req_len;
  logic                 mem_valid;
  logic                 mem_ready;
  logic [AW-1:0]        mem_addr;
  logic [DW-1:0]        mem_wdata;
  logic                 mem_we;
  logic [IDW-1:0]       gnt_id;
  logic                 busy;

  logic [LW-1:0]        cur_len;
  assign req_len = {NREQ{cur_len}};

  mem_in_arb #(.NREQ(NREQ), .AW(AW), .DW(DW), .LW(LW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_we(req_we), .req_len(req_len),
    .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .gnt_id(gnt_id), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [3:0] len;
    logic [3:0] rv;
    logic       mr;
    logic       ev;
    logic [3:0] err;
    logic [1:0] eg;
    logic       eb;
    int         sel;   // requester whose slice should appear on mem_*, 4 = all zero
  } vec_t;

  vec_t vq[$];
  int   errors = 0;
  int   checks = 0;

  function automatic logic [31:0] exp_addr(int s);
    return (s < 4) ? 32'(32'h1000_0000 * (s + 1) + 32'h44) : 32'h0;
  endfunction

  function automatic logic [31:0] exp_wdata(int s);
    return (s < 4) ? 32'(32'hD0D0_0000 + s) : 32'h0;
  endfunction

  function automatic logic exp_we(int s);
    return (s < 4) ? (s % 2 == 1) : 1'b0;
  endfunction

  task automatic chk(input string nm, input int row, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s row %0d: got %0h want %0h", nm, row, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic [3:0] l, input logic [3:0] v, input logic m,
                     input logic ev, input logic [3:0] er, input logic [1:0] eg,
                     input logic eb, input int s);
    vec_t t;
    t.rst = r; t.len = l; t.rv = v; t.mr = m;
    t.ev = ev; t.err = er; t.eg = eg; t.eb = eb; t.sel = s;
    vq.push_back(t);
  endtask

  initial begin
    int beats;
    int cyc;
    logic seen_busy;

    rst = 1'b1; req_valid = '0; mem_ready = 1'b0; cur_len = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_addr[i*AW +: AW]  = exp_addr(i);
      req_wdata[i*DW +: DW] = exp_wdata(i);
      req_we[i]             = exp_we(i);
    end

    // Single burst: req0 len=3, 4 consecutive beats starting one cycle after the request
    add(1, 3, 4'h0, 1, 0, 4'h0, 0, 0, 4);
    add(0, 3, 4'h1, 1, 0, 4'h0, 0, 0, 4);
    for (int i = 0; i < 4; i++) add(0, 3, 4'h1, 1, 1, 4'h1, 0, 1, 0);
    add(0, 3, 4'h0, 1, 0, 4'h0, 0, 0, 4);
    // All four valid, len=0: grants 0,1,2,3,0 with a bubble between each
    add(1, 0, 4'h0, 1, 0, 4'h0, 0, 0, 4);
    add(0, 0, 4'hF, 1, 0, 4'h0, 0, 0, 4);
    add(0, 0, 4'hF, 1, 1, 4'h1, 0, 1, 0);
    add(0, 0, 4'hF, 1, 0, 4'h0, 0, 0, 4);
    add(0, 0, 4'hF, 1, 1, 4'h2, 1, 1, 1);
    add(0, 0, 4'hF, 1, 0, 4'h0, 1, 0, 4);
    add(0, 0, 4'hF, 1, 1, 4'h4, 2, 1, 2);
    add(0, 0, 4'hF, 1, 0, 4'h0, 2, 0, 4);
    add(0, 0, 4'hF, 1, 1, 4'h8, 3, 1, 3);
    add(0, 0, 4'hF, 1, 0, 4'h0, 3, 0, 4);
    add(0, 0, 4'hF, 1, 1, 4'h1, 0, 1, 0);
    add(0, 0, 4'h0, 1, 0, 4'h0, 0, 0, 4);
    // Backpressure: req1 len=1, mem_ready low 3 cycles, then 2 handshakes
    add(1, 1, 4'h0, 0, 0, 4'h0, 0, 0, 4);
    add(0, 1, 4'h2, 0, 0, 4'h0, 0, 0, 4);
    for (int i = 0; i < 3; i++) add(0, 1, 4'h2, 0, 1, 4'h0, 1, 1, 1);
    for (int i = 0; i < 2; i++) add(0, 1, 4'h2, 1, 1, 4'h2, 1, 1, 1);
    add(0, 1, 4'h0, 1, 0, 4'h0, 1, 0, 4);
    // Lock: req2 len=3 while req0 waits; req0 wins after 4 beats and one bubble
    add(0, 3, 4'h4, 1, 0, 4'h0, 1, 0, 4);
    for (int i = 0; i < 4; i++) add(0, 3, 4'h5, 1, 1, 4'h4, 2, 1, 2);
    add(0, 3, 4'h1, 1, 0, 4'h0, 2, 0, 4);
    // Gap: req0 burst, valid dropped for 2 cycles, lock and slice held
    add(0, 3, 4'h1, 1, 1, 4'h1, 0, 1, 0);
    for (int i = 0; i < 2; i++) add(0, 3, 4'h0, 1, 0, 4'h1, 0, 1, 0);
    for (int i = 0; i < 3; i++) add(0, 3, 4'h1, 1, 1, 4'h1, 0, 1, 0);
    add(0, 3, 4'h0, 1, 0, 4'h0, 0, 0, 4);
    // Reset mid-burst after 2 of 4 beats: rr_ptr returns to 0, so req0 beats req3
    add(0, 3, 4'h8, 1, 0, 4'h0, 0, 0, 4);
    for (int i = 0; i < 2; i++) add(0, 3, 4'h8, 1, 1, 4'h8, 3, 1, 3);
    add(1, 3, 4'h9, 1, 0, 4'h0, 0, 0, 4);
    add(0, 3, 4'h9, 1, 0, 4'h0, 0, 0, 4);
    add(0, 3, 4'h9, 1, 1, 4'h1, 0, 1, 0);

    foreach (vq[r]) begin
      @(negedge clk);
      rst = vq[r].rst; cur_len = vq[r].len; req_valid = vq[r].rv; mem_ready = vq[r].mr;
      #1;
      chk("mem_valid", r, 32'(mem_valid), 32'(vq[r].ev));
      chk("req_ready", r, 32'(req_ready), 32'(vq[r].err));
      chk("gnt_id",    r, 32'(gnt_id),    32'(vq[r].eg));
      chk("busy",      r, 32'(busy),      32'(vq[r].eb));
      chk("mem_addr",  r, mem_addr,       exp_addr(vq[r].sel));
      chk("mem_wdata", r, mem_wdata,      exp_wdata(vq[r].sel));
      chk("mem_we",    r, 32'(mem_we),    32'(exp_we(vq[r].sel)));
    end

    // req_len is sampled only at grant: len=2 burst must give 3 beats although len drops to 0
    @(negedge clk); rst = 1'b1; req_valid = '0;
    @(negedge clk); rst = 1'b0; cur_len = 4'd2; req_valid = 4'h4; mem_ready = 1'b1;
    beats = 0; cyc = 0; seen_busy = 1'b0;
    while (cyc < 30) begin
      @(negedge clk); #1;
      if (busy) begin
        seen_busy = 1'b1;
        cur_len = 4'd0;
      end
      if (mem_valid && mem_ready) beats++;
      if (seen_busy && !busy) break;
      cyc++;
    end
    chk("len_timeout", 0, 32'(cyc < 30), 32'd1);
    chk("len_beats",   0, 32'(beats),    32'd3);
    chk("len_gnt",     0, 32'(gnt_id),   32'd2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
